// File: rtl/alu_pkg.sv
// Shared ALU function codes and arbiter FSM encoding for the shared-ALU slice.
package alu_pkg;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_AND   = 6'b011000;
  localparam logic [5:0] ALU_OR    = 6'b011110;
  localparam logic [5:0] ALU_XOR   = 6'b010110;
  localparam logic [5:0] ALU_NOR   = 6'b010001;
  localparam logic [5:0] ALU_PASSA = 6'b011010;
  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [5:0] ALU_EQ    = 6'b110011;
  localparam logic [5:0] ALU_NEQ   = 6'b110001;
  localparam logic [5:0] ALU_LT    = 6'b110101;
  localparam logic [5:0] ALU_LEZ   = 6'b111101;
  localparam logic [5:0] ALU_LTZ   = 6'b111011;
  localparam logic [5:0] ALU_GTZ   = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 32-bit ALU: add/sub, logic, shift and compare groups
// selected by fun[5:4].
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  fun,
  input  logic        sign,
  output logic [31:0] z
);

  logic [31:0] addsub_s;
  logic        lt_s;
  logic        neg_s;
  logic        zero_s;
  logic        flag_s;

  assign addsub_s = fun[0] ? (a - b) : (a + b);
  assign lt_s     = sign ? ($signed(a) < $signed(b)) : (a < b);
  // Zero-relative compares treat A as negative only in signed mode.
  assign neg_s    = sign & a[31];
  assign zero_s   = (a == 32'h0000_0000);

  // Compare flag decode; unknown compare codes yield 0.
  always_comb begin
    flag_s = 1'b0;
    case (fun[3:0])
      4'b0011: flag_s = (a == b);
      4'b0001: flag_s = (a != b);
      4'b0101: flag_s = lt_s;
      4'b1101: flag_s = neg_s | zero_s;
      4'b1011: flag_s = neg_s;
      4'b1111: flag_s = ~neg_s & ~zero_s;
      default: flag_s = 1'b0;
    endcase
  end

  // Result mux by operation group.
  always_comb begin
    z = 32'h0000_0000;
    case (fun[5:4])
      2'b00: z = addsub_s;
      2'b01: begin
        case (fun[3:0])
          4'b1000: z = a & b;
          4'b1110: z = a | b;
          4'b0110: z = a ^ b;
          4'b0001: z = ~(a | b);
          4'b1010: z = a;
          default: z = a;
        endcase
      end
      2'b10: begin
        case (fun[1:0])
          2'b00:   z = b << a[4:0];
          2'b01:   z = b >> a[4:0];
          2'b11:   z = $unsigned($signed(b) >>> a[4:0]);
          default: z = b;
        endcase
      end
      2'b11:   z = {31'h0000_0000, flag_s};
      default: z = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu_core between two valid/ready requesters,
// with a registered result held until the owner accepts it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [5:0]       req0_fun,
  input  logic [5:0]       req1_fun,
  input  logic             req0_sign,
  input  logic             req1_sign,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_z,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  arb_state_t       state_r, state_nxt_s;
  logic             prio_r;
  logic             owner_r;
  logic [31:0]      a_r, b_r;
  logic [5:0]       fun_r;
  logic             sign_r;
  logic [31:0]      rsp_z_r;
  logic             rsp_valid_r;
  logic [CNT_W-1:0] op_count_r;
  logic             grant_s;
  logic             accept_s;
  logic             rsp_done_s;
  logic [31:0]      alu_z_s;

  alu_core u_alu (
    .a    (a_r),
    .b    (b_r),
    .fun  (fun_r),
    .sign (sign_r),
    .z    (alu_z_s)
  );

  // Grant selection: lone requester wins, contention resolved by prio_r.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = prio_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s   = (state_r == IDLE) && (req0_valid || req1_valid);
  assign rsp_done_s = (state_r == RESP) && (owner_r ? rsp1_ready : rsp0_ready);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? EXEC : IDLE;
      EXEC:    state_nxt_s = RESP;
      RESP:    state_nxt_s = rsp_done_s ? IDLE : RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, operand capture, result register and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      prio_r      <= 1'b0;
      owner_r     <= 1'b0;
      a_r         <= 32'h0000_0000;
      b_r         <= 32'h0000_0000;
      fun_r       <= 6'b000000;
      sign_r      <= 1'b0;
      rsp_z_r     <= 32'h0000_0000;
      rsp_valid_r <= 1'b0;
      op_count_r  <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        owner_r <= grant_s;
        a_r     <= grant_s ? req1_a    : req0_a;
        b_r     <= grant_s ? req1_b    : req0_b;
        fun_r   <= grant_s ? req1_fun  : req0_fun;
        sign_r  <= grant_s ? req1_sign : req0_sign;
      end
      if (state_r == EXEC) begin
        rsp_z_r     <= alu_z_s;
        rsp_valid_r <= 1'b1;
      end
      if (rsp_done_s) begin
        rsp_valid_r <= 1'b0;
        prio_r      <= ~owner_r;
        if (op_count_r != {CNT_W{1'b1}}) begin
          op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign req0_ready = !reset && accept_s && !grant_s;
  assign req1_ready = !reset && accept_s && grant_s;
  assign rsp0_valid = rsp_valid_r && !owner_r;
  assign rsp1_valid = rsp_valid_r && owner_r;
  assign rsp_z      = rsp_z_r;
  assign busy       = (state_r != IDLE);
  assign op_count   = op_count_r;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 32-bit ALU between two requesters (e.g. the main execute path and the branch/compare path of the multi-cycle core) using valid/ready handshakes and round-robin arbitration. Captures the winner's operands, evaluates them in a single ALU instance, and holds the registered result until the winner accepts it. A saturating count of completed operations is exposed for performance monitoring.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.
- `clk` input 1: clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req0_valid`, `req1_valid` input 1 each: requester n presents an operation.
- `req0_ready`, `req1_ready` output 1 each: operation of requester n accepted this cycle when valid and ready are both high.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` input 32 each: operands A and B.
- `req0_fun`, `req1_fun` input 6 each: ALUFun code.
- `req0_sign`, `req1_sign` input 1 each: signed/unsigned select for add/sub/compare.
- `rsp0_valid`, `rsp1_valid` output 1 each: result for requester n is on `rsp_z`.
- `rsp0_ready`, `rsp1_ready` input 1 each: requester n takes its result.
- `rsp_z` output 32: registered ALU result, shared by both response channels.
- `busy` output 1: high in every state except IDLE.
- `op_count` output CNT_W: completed operations; saturates at all-ones.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant is combinational. If only one requester is valid, it is granted. If both are valid, the requester named by the priority pointer `prio` is granted. The granted `reqN_ready` is high and the other is low. On accept, latch A, B, fun, sign and the owner id, then go to EXEC. Stay in IDLE if neither requester is valid.
- EXEC: the ALU evaluates the latched operands. The result is registered into `rsp_z`. `rspN_valid` rises for the owner. Go to RESP.
- RESP: `rsp_z` and `rspN_valid` hold steady until `rspN_ready` is high for the owner. On that handshake:
  - drop valid;
  - increment `op_count` (saturating);
  - set `prio` to the non-owner;
  - return to IDLE.
- Both `reqN_ready` stay low outside IDLE. A valid held by the losing requester persists and is served next.
- `rspN_ready` from the non-owner is ignored.
- ALU semantics, by fun[5:4]:
  - 00 add/sub (fun[0] = 1 means subtract);
  - 01 logic (AND, OR, XOR, NOR, pass-A);
  - 10 shift of B by A[4:0] (SLL, SRL, SRA);
  - 11 compare, giving `{31'b0, flag}` (EQ, NEQ, LT, LEZ, LTZ, GTZ).
- Add/sub wraps modulo 2^32. Undefined logic codes return A. Undefined compare codes return 0.

## Timing
- Reset values: state IDLE, `prio` = 0, `rsp_z` = 0, both `rspN_valid` = 0, `busy` = 0, `op_count` = 0. Both `reqN_ready` read 0 while `reset` is high.
- Latency: accept in cycle T, `rspN_valid` high from cycle T+2. Back-to-back operations with immediate `rsp_ready` complete every 3 cycles.
- A request presented in the same cycle that RESP completes is not accepted until the next cycle (IDLE).
- Reset mid-operation (EXEC or RESP) discards the operation: no response, `op_count` does not increment.
- At the all-ones value, `op_count` holds.
- Request inputs are sampled only at the accept edge; later changes do not affect the result.

## Structure
- Shared package `alu_pkg`:
  - ALUFun code constants: ADD=000000, SUB=000001, AND=011000, OR=011110, XOR=010110, NOR=010001, PASSA=011010, SLL=100000, SRL=100001, SRA=100011, EQ=110011, NEQ=110001, LT=110101, LEZ=111101, LTZ=111011, GTZ=111111;
  - FSM state encoding.
- One sub-module, `alu_core`: purely combinational (A, B, fun, sign → Z), instantiated once. The arbiter holds all sequential state.

## Test plan
- Single ADD: req0 A=0x7FFFFFFF, B=0x1, fun=ADD. Accept at T. `rsp0_valid` at T+2 with `rsp_z`=0x80000000; `op_count`=1 after the response handshake.
- Contention: both valid at T; req0 A=5, B=3, SUB, sign=1; req1 A=4, B=0xF0, SLL.
  - req0 is served first: `rsp_z`=2.
  - req1 is accepted in the first IDLE cycle after req0's response handshake: `rsp_z`=0xF00.
  - `prio` ends at 0.
- Round-robin: both held valid continuously for 4 operations with `rsp_ready` tied high. Grants alternate 0,1,0,1; an operation completes every 3 cycles.
- Backpressure: `rsp1_ready` low for 5 cycles after a req1 compare (LT, sign=1, A=-1, B=1). `rsp_z`=1 stays stable; both `reqN_ready` stay 0; `rsp0_ready` pulses are ignored.
- Mid-op reset: assert `reset` in the EXEC cycle. The next cycle shows IDLE, `rspN_valid`=0, `op_count` unchanged, `prio`=0.
- Saturation: `CNT_W`=2, run 5 operations. `op_count` reads 1, 2, 3, 3, 3.
